// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the shared 13-bit address / 8-bit data memory bus.
// Port 0 is the CPU fetch/execute path and port 1 is the program loader / DMA.
// The arbiter latches the winning request and sequences the mem_rd/mem_wr strobes
// with a programmable number of wait states.
// Writes below RAM_BASE (the ROM region) are rejected with an err pulse and never reach the bus.
module mem_bus_arbiter #(
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned WR_WAIT  = 1,
    parameter logic [12:0] RAM_BASE = 13'h1800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [12:0] addr0,
    input  logic [12:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The counter is loaded with WAIT-1 so that the strobe stays high for exactly WAIT cycles.
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_t      r_state;
    logic        r_owner;
    logic        r_lastOwner;
    logic        r_we;
    logic [3:0]  r_waitCnt;
    logic [1:0]  r_gnt;
    logic [1:0]  r_ack;
    logic        r_err;
    logic        r_memRd;
    logic        r_memWr;
    logic [12:0] r_memAddr;
    logic [7:0]  r_memWdata;
    logic [7:0]  r_rdata;

    logic        w_anyReq;
    logic        w_winner;
    logic        w_romWrite;

    // A lone request wins outright.
    // When both ports request, the port that did not own the bus last time wins.
    always_comb begin
        w_anyReq   = req0 | req1;
        w_winner   = req1 & (~req0 | ~r_lastOwner);
        w_romWrite = r_we & (r_memAddr < RAM_BASE);
    end

    // Single FSM that owns every bus strobe and handshake output.
    // Everything is registered so the memory group sees glitch-free strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_lastOwner <= 1'b1;
            r_we        <= 1'b0;
            r_waitCnt   <= 4'd0;
            r_gnt       <= 2'b00;
            r_ack       <= 2'b00;
            r_err       <= 1'b0;
            r_memRd     <= 1'b0;
            r_memWr     <= 1'b0;
            r_memAddr   <= 13'd0;
            r_memWdata  <= 8'd0;
            r_rdata     <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 2'b00;
                    r_err <= 1'b0;
                    if (w_anyReq) begin
                        r_owner    <= w_winner;
                        r_we       <= w_winner ? we1 : we0;
                        r_memAddr  <= w_winner ? addr1 : addr0;
                        r_memWdata <= w_winner ? wdata1 : wdata0;
                        r_gnt      <= w_winner ? 2'b10 : 2'b01;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_romWrite) begin
                        r_ack[r_owner] <= 1'b1;
                        r_err          <= 1'b1;
                        r_state        <= DONE;
                    end else begin
                        r_waitCnt <= r_we ? WR_LOAD : RD_LOAD;
                        r_memRd   <= ~r_we;
                        r_memWr   <= r_we;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_waitCnt == 4'd0) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_memRd        <= 1'b0;
                        r_memWr        <= 1'b0;
                        r_ack[r_owner] <= 1'b1;
                        r_state        <= DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                DONE: begin
                    r_ack       <= 2'b00;
                    r_err       <= 1'b0;
                    r_gnt       <= 2'b00;
                    r_lastOwner <= r_owner;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt[0];
    assign gnt1      = r_gnt[1];
    assign ack0      = r_ack[0];
    assign ack1      = r_ack[1];
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_rd    = r_memRd;
    assign mem_wr    = r_memWr;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// Directed table rows and hand-written corner sequences run first, followed by randomized traffic.
// Random traffic is compared against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int          RD_WAIT_TB  = 2;
    localparam int          WR_WAIT_TB  = 1;
    localparam logic [12:0] RAM_BASE_TB = 13'h1800;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [12:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1, err;
    logic [7:0]  rdata;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_rdata;

    int passCount  = 0;
    int totalCount = 0;

    // Memory seen by the DUT, and the reference model's own view of it.
    logic [7:0] memArr [0:8191];
    logic [7:0] refMem [0:8191];
    logic [7:0] refRdata;
    int         refLastOwner;

    typedef struct {
        int          port;
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic        expErr;
        int          expCycles;
        logic [7:0]  expRdata;
    } vec_t;

    vec_t vecs [9];

    mem_bus_arbiter #(
        .RD_WAIT  (RD_WAIT_TB),
        .WR_WAIT  (WR_WAIT_TB),
        .RAM_BASE (RAM_BASE_TB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Power-on memory contents, with a few addresses pinned to known values for the directed rows.
    function automatic logic [7:0] initByte(input int i);
        logic [7:0] b;
        b = 8'((i * 7 + 3) ^ (i >> 5));
        if (i == 32'h1805) b = 8'hA5;
        if (i == 32'h0010) b = 8'h11;
        if (i == 32'h17FF) b = 8'hC3;
        return b;
    endfunction

    // Behavioural memory on the bus: combinational read, write on the clock edge while mem_wr is high.
    initial begin
        for (int i = 0; i < 8192; i++) memArr[i] = initByte(i);
        forever begin
            @(posedge clk);
            if (mem_wr) memArr[mem_addr] = mem_wdata;
        end
    end

    assign mem_rdata = memArr[mem_addr];

    // Compares one observed value against its expected value and tallies the result.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    endtask

    // Drives one port's request fields.
    task automatic applyStimulus(input int port, input logic we, input logic [12:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end
    endtask

    // Reference model: in IDLE the sole requester wins; with two requesters, the port that was not the last owner wins.
    function automatic int modelWinner(input logic r0, input logic r1);
        if (r0 && r1) return (refLastOwner == 1) ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    task automatic modelReset();
        refLastOwner = 1;
        refRdata     = 8'h00;
    endtask

    task automatic modelCommit(input int port, input logic we, input logic [12:0] addr, input logic [7:0] wdata);
        refLastOwner = port;
        if (!we) refRdata = refMem[addr];
        else if (addr >= RAM_BASE_TB) refMem[addr] = wdata;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ctl"}, 32'({gnt0, gnt1, ack0, ack1, err, mem_rd, mem_wr}), 32'd0);
        checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, " rdata"}, 32'(rdata), 32'd0);
    endtask

    // Follows one transaction from the request edge to the return to IDLE.
    // Starts just after an edge where the arbiter is idle and the request is already driven.
    task automatic serveAndCheck(input int expPort, input logic expWe, input logic [12:0] expAddr,
                                 input logic [7:0] expWdata, input logic expErr, input int expCycles,
                                 input logic [7:0] expRdata, input bit dropEarly, input bit dropAfter,
                                 input string tag);
        int         cyc = 0;
        int         rdCnt = 0;
        int         wrCnt = 0;
        int         badPayload = 0;
        int         badExcl = 0;
        bit         gotAck = 0;
        bit         gntOk = 0;
        bit         ackGnt = 0;
        int         ackPort = -1;
        logic       ackErr = 1'b0;
        logic [7:0] ackRdata = 8'h00;
        while (!gotAck && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                gntOk = (expPort == 0) ? (gnt0 && !gnt1) : (gnt1 && !gnt0);
                if (dropEarly) begin
                    if (expPort == 0) req0 = 1'b0;
                    else req1 = 1'b0;
                end
            end
            if (gnt0 && gnt1) badExcl++;
            if (mem_rd && mem_wr) badExcl++;
            if (mem_addr !== expAddr) badPayload++;
            if (mem_rd) rdCnt++;
            if (mem_wr) begin
                wrCnt++;
                if (mem_wdata !== expWdata) badPayload++;
            end
            if (ack0 || ack1) begin
                gotAck   = 1;
                ackPort  = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
                ackErr   = err;
                ackRdata = rdata;
                ackGnt   = (expPort == 0) ? gnt0 : gnt1;
            end
        end
        checkOutput({tag, " gnt"}, 32'(gntOk), 32'd1);
        checkOutput({tag, " ack_seen"}, 32'(gotAck), 32'd1);
        checkOutput({tag, " ack_port"}, 32'(ackPort), 32'(expPort));
        checkOutput({tag, " ack_with_gnt"}, 32'(ackGnt), 32'd1);
        checkOutput({tag, " ack_cycle"}, 32'(cyc), 32'(expCycles));
        checkOutput({tag, " err"}, 32'(ackErr), 32'(expErr));
        checkOutput({tag, " rdata"}, 32'(ackRdata), 32'(expRdata));
        checkOutput({tag, " rd_cycles"}, 32'(rdCnt), expWe ? 32'd0 : 32'(RD_WAIT_TB));
        checkOutput({tag, " wr_cycles"}, 32'(wrCnt), (expWe && !expErr) ? 32'(WR_WAIT_TB) : 32'd0);
        checkOutput({tag, " bus_payload"}, 32'(badPayload), 32'd0);
        checkOutput({tag, " exclusive"}, 32'(badExcl), 32'd0);
        if (dropAfter) begin
            if (expPort == 0) req0 = 1'b0;
            else req1 = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, " release"}, 32'({gnt0, gnt1, ack0, ack1, err, mem_rd, mem_wr}), 32'd0);
    endtask

    // Derives the expected outcome of the port's currently driven request from the model and checks it.
    task automatic serveModel(input int port, input bit dropEarly, input bit dropAfter, input string tag);
        logic        w;
        logic [12:0] a;
        logic [7:0]  d;
        logic        e;
        int          c;
        logic [7:0]  r;
        w = (port == 1) ? we1 : we0;
        a = (port == 1) ? addr1 : addr0;
        d = (port == 1) ? wdata1 : wdata0;
        e = w && (a < RAM_BASE_TB);
        c = e ? 2 : ((w ? WR_WAIT_TB : RD_WAIT_TB) + 2);
        r = w ? refRdata : refMem[a];
        serveAndCheck(port, w, a, d, e, c, r, dropEarly, dropAfter, tag);
        modelCommit(port, w, a, d);
    endtask

    initial begin
        int ackDuringReset;
        int idleActivity;
        int first;
        logic r0, r1;

        vecs[0] = '{0, 1'b0, 13'h1805, 8'h00, 1'b0, 4, 8'hA5};
        vecs[1] = '{1, 1'b1, 13'h1FFF, 8'h3C, 1'b0, 3, 8'hA5};
        vecs[2] = '{0, 1'b1, 13'h0010, 8'hFF, 1'b1, 2, 8'hA5};
        vecs[3] = '{1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 4, 8'h3C};
        vecs[4] = '{0, 1'b0, 13'h0010, 8'h00, 1'b0, 4, 8'h11};
        vecs[5] = '{1, 1'b1, 13'h17FF, 8'h77, 1'b1, 2, 8'h11};
        vecs[6] = '{0, 1'b1, 13'h1800, 8'h66, 1'b0, 3, 8'h11};
        vecs[7] = '{1, 1'b0, 13'h1800, 8'h00, 1'b0, 4, 8'h66};
        vecs[8] = '{0, 1'b0, 13'h17FF, 8'h00, 1'b0, 4, 8'hC3};

        for (int i = 0; i < 8192; i++) refMem[i] = initByte(i);
        modelReset();

        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 13'd0; addr1 = 13'd0; wdata0 = 8'd0; wdata1 = 8'd0;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed rows covering reads, RAM writes, ROM write protection and the RAM_BASE boundary.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            serveAndCheck(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expErr,
                          vecs[i].expCycles, vecs[i].expRdata, 1'b0, 1'b1, $sformatf("vec%0d", i));
            modelCommit(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
        end

        // Contention from reset: both ports read continuously, so grants must alternate 0,1,0,1.
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkAllZero("reset2");
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 1'b0, 13'h1805, 8'h00);
        applyStimulus(1, 1'b0, 13'h1FFF, 8'h00);
        for (int k = 0; k < 4; k++) begin
            serveAndCheck(k % 2, 1'b0, (k % 2 == 0) ? 13'h1805 : 13'h1FFF, 8'h00, 1'b0, 4,
                          (k % 2 == 0) ? 8'hA5 : 8'h3C, 1'b0, 1'b0, $sformatf("rr%0d", k));
            modelCommit(k % 2, 1'b0, (k % 2 == 0) ? 13'h1805 : 13'h1FFF, 8'h00);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;

        // Reset asserted during the second ACCESS cycle of a read: the strobe must drop without a clock edge.
        applyStimulus(0, 1'b0, 13'h0100, 8'h00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("midrst mem_rd_before", 32'(mem_rd), 32'd1);
        applyStimulus(1, 1'b0, 13'h1805, 8'h00);
        reset = 1'b0;
        #1;
        checkAllZero("midrst");
        req0 = 1'b0;
        ackDuringReset = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (ack0 || ack1 || gnt0 || gnt1 || mem_rd) ackDuringReset++;
        end
        checkOutput("midrst no_activity", 32'(ackDuringReset), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        serveModel(1, 1'b0, 1'b1, "postrst");

        // Request dropped during SETUP still completes; afterwards the arbiter must stay idle.
        applyStimulus(0, 1'b0, 13'h1FFF, 8'h00);
        serveModel(0, 1'b1, 1'b0, "drop");
        idleActivity = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (gnt0 || gnt1 || ack0 || ack1 || mem_rd || mem_wr) idleActivity++;
        end
        checkOutput("drop stays_idle", 32'(idleActivity), 32'd0);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 30; it++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            if (r0) applyStimulus(0, ($urandom_range(0, 2) == 0),
                                  ($urandom_range(0, 1) == 1) ? 13'(RAM_BASE_TB + 13'($urandom_range(0, 2047)))
                                                              : 13'($urandom_range(0, 8191)),
                                  8'($urandom));
            if (r1) applyStimulus(1, ($urandom_range(0, 2) == 0),
                                  ($urandom_range(0, 1) == 1) ? 13'(RAM_BASE_TB + 13'($urandom_range(0, 2047)))
                                                              : 13'($urandom_range(0, 8191)),
                                  8'($urandom));
            first = modelWinner(r0, r1);
            serveModel(first, 1'b0, 1'b1, $sformatf("rand%0da", it));
            if (r0 && r1) serveModel(1 - first, 1'b0, 1'b1, $sformatf("rand%0db", it));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 13-bit address / 8-bit data memory bus (ROM + RAM) between two requesters: port 0 = CPU core fetch/execute path, port 1 = program loader / DMA.
- Round-robin arbitration, registered request latching, wait-state sequencing of mem_rd/mem_wr strobes, write protection of the ROM region.
- Sits between the requesters and the addr_decode/ram/rom group; all memory strobes originate here.

Parameters:
- RD_WAIT, 2, number of cycles mem_rd is held asserted per read (1..15)
- WR_WAIT, 1, number of cycles mem_wr is held asserted per write (1..15)
- RAM_BASE, 13'h1800, lowest RAM address; addresses below it are ROM (read-only)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req0 / req1  input  1  access request, port 0 / port 1
- we0 / we1  input  1  1 = write, 0 = read; sampled with request
- addr0 / addr1  input  13  access address
- wdata0 / wdata1  input  8  write data
- gnt0 / gnt1  output  1  port owns the bus (one-hot or zero)
- ack0 / ack1  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse with ack: rejected ROM write
- rdata  output  8  read data, valid in ack cycle, held until next read completes
- mem_addr  output  13  bus address
- mem_wdata  output  8  bus write data
- mem_rd / mem_wr  output  1  bus strobes, never both high
- mem_rdata  input  8  bus read data

Behaviour:
- Reset (reset=0, async): state IDLE; gnt*, ack*, err, mem_rd, mem_wr = 0; mem_addr = 0; mem_wdata = 0; rdata = 0; last_owner = 1, so port 0 wins the first contest. Reset mid-transaction aborts it immediately: strobes drop without waiting for a clock, and no ack is issued.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If only one req is high, that port wins.
  - If both are high, the port other than last_owner wins.
  - On the edge the request is seen: latch owner, we, addr, wdata into mem_addr/mem_wdata; set gnt[owner]=1; go to SETUP.
- SETUP (1 cycle): address stable, strobes low.
  - Write with addr < RAM_BASE: go to DONE with err set; mem_wr is never asserted.
  - Otherwise load wait counter with RD_WAIT-1 or WR_WAIT-1 and go to ACCESS.
- ACCESS: mem_rd (read) or mem_wr (write) high throughout; counter decrements each cycle.
  - At count 0: for reads, capture mem_rdata into rdata; drop strobe; go to DONE.
- DONE (1 cycle): ack[owner]=1, plus err if the write was rejected; last_owner <= owner; next edge returns to IDLE with gnt cleared.
- Latency: req seen at edge N → gnt high after N → ack high in the cycle after edge N+1+WAIT. Total occupancy is WAIT+3 cycles (read: RD_WAIT+3, write: WR_WAIT+3).
- Requester protocol:
  - Hold req, we, addr and wdata until ack; input changes after latching are ignored.
  - If req drops mid-transaction, the transaction still completes and is acked.
  - If req is still high in IDLE after ack, it is a new request and competes in round-robin.
- Simultaneous events: a new req arriving during SETUP/ACCESS/DONE waits; arbitration happens only in IDLE. A port is never starved: with both requesting continuously, grants alternate 0,1,0,1.
- Invariants: at most one gnt high; at most one ack high; ack only to the granted port; mem_addr constant from SETUP through DONE.
- rdata is unchanged by writes and rejected writes.

Test Plan:
- Single read: port 0 reads 13'h1805 (RD_WAIT=2), memory returns 8'hA5 → gnt0 after first edge, mem_rd high exactly 2 cycles, ack0 one cycle with rdata=8'hA5, total 5 cycles, gnt1/ack1 stay 0.
- RAM write: port 1 writes 8'h3C to 13'h1FFF (WR_WAIT=1) → mem_wr high 1 cycle with mem_addr=13'h1FFF and mem_wdata=8'h3C, ack1 pulse, err=0, rdata unchanged.
- ROM write protect: port 0 writes 8'hFF to 13'h0010 → mem_wr never asserts, ack0 with err=1 in the 3rd cycle after request.
- Contention: req0 and req1 held high from reset, both reading → grant order 0,1,0,1; each ack matches its own address data; never two gnts high at once.
- Reset mid-access: reset driven low during the 2nd ACCESS cycle of a read → mem_rd drops immediately, all outputs 0, no ack; after release, a pending req1 is served normally.
- Dropped request: req0 deasserted during SETUP → transaction completes and ack0 is still pulsed; with req0 low afterwards, the arbiter stays in IDLE.
